// File: rtl/mmio_port_responder_pkg.sv
// ============================================================================
// mmio_pkg : register offsets, STATUS bit indices and timer states shared by
//            the MMIO port responder and its bench.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mmio_pkg;

    // Word offsets, compared against Address[4:2]
    localparam logic [2:0] OFF_PORT_OUT    = 3'd0;
    localparam logic [2:0] OFF_PORT_IN     = 3'd1;
    localparam logic [2:0] OFF_STATUS      = 3'd2;
    localparam logic [2:0] OFF_TIMER_LOAD  = 3'd3;
    localparam logic [2:0] OFF_TIMER_COUNT = 3'd4;
    localparam logic [2:0] OFF_TIMER_CTRL  = 3'd5;

    localparam int STATUS_TIMER_BIT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

`default_nettype wire

// File: rtl/mmio_port_responder_if.sv
// ============================================================================
// mmio_port_responder_if : MEM-stage data bus as seen by an MMIO slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mmio_port_responder_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output MemWrite, MemRead, Address, WriteData,
        input  ReadData, Hit
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData,
        output ReadData, Hit
    );
endinterface

`default_nettype wire

// File: rtl/mmio_port_responder_input_sync_edge.sv
// ============================================================================
// input_sync_edge : two-flop synchronizer plus history flop; flags rising
//                   edges of the synchronized value for one cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module input_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] AsyncIn,
    output logic [WIDTH-1:0] Synced,
    output logic [WIDTH-1:0] RisePulse
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= AsyncIn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign Synced    = s2;
    assign RisePulse = s2 & ~s3;

endmodule

`default_nettype wire

// File: rtl/mmio_port_responder.sv
// ============================================================================
// mmio_port_responder : MEM-stage MMIO slave with output port, synchronized
//                       input port, sticky edge capture and reload timer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0400,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    mmio_port_responder_if.slave bus,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                TimerIrq
);

    logic [IN_WIDTH-1:0] synced;
    logic [IN_WIDTH-1:0] rise_pulse;

    input_sync_edge #(.WIDTH(IN_WIDTH)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .AsyncIn   (PortIn),
        .Synced    (synced),
        .RisePulse (rise_pulse)
    );

    logic [2:0]  offset;
    logic        hit;
    logic        wr_en;
    logic        rd_en;
    logic        status_clr;
    logic        ctrl_wr;
    logic        expire_evt;

    logic [31:0]         port_out;
    logic [31:0]         timer_load;
    logic [31:0]         timer_count;
    logic [IN_WIDTH-1:0] edge_flags;
    logic                timer_expired;
    timer_state_t        state;
    logic [31:0]         read_data;

    assign offset = bus.Address[4:2];
    assign hit    = (bus.Address[31:5] == BASE_ADDR[31:5]) && (bus.Address[1:0] == 2'b00);
    // A simultaneous read+write strobe is a pure write: no data, no clear-on-read
    assign wr_en  = hit && bus.MemWrite;
    assign rd_en  = hit && bus.MemRead && !bus.MemWrite;

    assign status_clr = rd_en && (offset == OFF_STATUS);
    assign ctrl_wr    = wr_en && (offset == OFF_TIMER_CTRL);
    assign expire_evt = (state == RUN) && !ctrl_wr && (timer_count == 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            port_out      <= '0;
            timer_load    <= '0;
            edge_flags    <= '0;
            timer_expired <= 1'b0;
        end else begin
            if (wr_en && (offset == OFF_PORT_OUT))
                port_out <= bus.WriteData;
            if (wr_en && (offset == OFF_TIMER_LOAD))
                timer_load <= bus.WriteData;
            // New events win over the clear issued in the same cycle
            edge_flags    <= (status_clr ? '0 : edge_flags) | rise_pulse;
            timer_expired <= (status_clr ? 1'b0 : timer_expired) | expire_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer_count <= '0;
        end else if (ctrl_wr) begin
            if (bus.WriteData[0]) begin
                state       <= RUN;
                timer_count <= timer_load;
            end else begin
                state <= IDLE;
            end
        end else begin
            case (state)
                IDLE: timer_count <= timer_count;
                RUN: begin
                    // A zero load parks the counter at 0 forever
                    if (timer_count == 32'd1)
                        timer_count <= timer_load;
                    else if (timer_count != 32'd0)
                        timer_count <= timer_count - 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        read_data = '0;
        if (rd_en) begin
            case (offset)
                OFF_PORT_OUT:    read_data = port_out;
                OFF_PORT_IN:     read_data = 32'(synced);
                OFF_STATUS: begin
                    read_data                   = 32'(edge_flags);
                    read_data[STATUS_TIMER_BIT] = timer_expired;
                end
                OFF_TIMER_LOAD:  read_data = timer_load;
                OFF_TIMER_COUNT: read_data = timer_count;
                OFF_TIMER_CTRL:  read_data = 32'(state == RUN);
                default:         read_data = '0;
            endcase
        end
    end

    assign bus.ReadData = read_data;
    assign bus.Hit      = hit;
    assign PortOut      = port_out;
    assign TimerIrq     = timer_expired;

endmodule

`default_nettype wire
